// File: rtl/sqrt_reconstruct.sv
// sqrt_reconstruct: rebuilds radicand = root*root + remainder with an iterative shift-add multiplier
module sqrt_reconstruct #(
  parameter int RADICAND_WIDTH = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [RADICAND_WIDTH/2-1:0]         root,
  input  logic [RADICAND_WIDTH/2:0]           remainder,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [RADICAND_WIDTH-1:0]           radicand,
  output logic                                non_canonical
);
  localparam int RTW = RADICAND_WIDTH / 2;
  localparam int RMW = RTW + 1;
  localparam int CW  = $clog2(RTW) + 1;
  typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} state_t;
  state_t                    r_state, w_next;
  logic [RADICAND_WIDTH-1:0] r_mcand, r_acc;
  logic [RTW-1:0]            r_mplier;
  logic [RMW-1:0]            r_rem;
  logic [CW-1:0]             r_cnt;
  logic [RADICAND_WIDTH:0]   w_sum;
  logic                      w_last;
  assign w_last    = r_cnt == CW'(RTW - 1);
  assign w_sum     = {1'b0, r_acc} + (RADICAND_WIDTH + 1)'(r_rem);
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  // state register
  always_ff @(posedge clk)
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  // next state: accept, iterate, add once, hold until downstream takes the result
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = in_valid ? MUL : IDLE;
      MUL:     w_next = w_last ? ADD : MUL;
      ADD:     w_next = DONE;
      default: w_next = out_ready ? IDLE : DONE;
    endcase
  end
  // datapath; the unshifted multiplicand still holds root for the canonical check
  always_ff @(posedge clk)
    if (reset) begin
      r_mcand       <= '0;
      r_mplier      <= '0;
      r_rem         <= '0;
      r_acc         <= '0;
      r_cnt         <= '0;
      radicand      <= '0;
      non_canonical <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_mcand  <= RADICAND_WIDTH'(root);
          r_mplier <= root;
          r_rem    <= remainder;
          r_acc    <= '0;
          r_cnt    <= '0;
        end
        MUL: begin
          if (r_mplier[0]) r_acc <= r_acc + (r_mcand << r_cnt);
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
        end
        ADD: begin
          radicand      <= w_sum[RADICAND_WIDTH-1:0];
          non_canonical <= (r_rem > {r_mcand[RTW-1:0], 1'b0}) | w_sum[RADICAND_WIDTH];
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_sqrt_reconstruct.sv
// tb_sqrt_reconstruct: scoreboard bench for sqrt_reconstruct at RADICAND_WIDTH=8
module tb_sqrt_reconstruct;
  localparam int W = 8, RT = 4, RM = 5;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 1;
  logic [RT-1:0] root = 0;
  logic [RM-1:0] remainder = 0;
  logic in_ready, out_valid, non_canonical;
  logic [W-1:0] radicand;
  typedef struct packed {logic [W-1:0] rad; logic nc;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;

  sqrt_reconstruct #(.RADICAND_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .root(root), .remainder(remainder), .out_valid(out_valid), .out_ready(out_ready),
    .radicand(radicand), .non_canonical(non_canonical));

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(int r, int m);
    int s;
    s = r * r + m;
    model.rad = s[W-1:0];
    model.nc  = (m > 2 * r) || (s > 255);
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        e = q.pop_front();
        chk("radicand", radicand, e.rad);
        chk("non_canonical", non_canonical, e.nc);
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(int r, int m, int erad, int enc, bit push);
    int t = 0;
    while (!in_ready && t < 100) begin step(1); t++; end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    in_valid = 1; root = RT'(r); remainder = RM'(m);
    if (push) q.push_back('{rad: W'(erad), nc: enc[0]});
    step(1);
    in_valid = 0;
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() > 0 || !in_ready) && t < 200) begin step(1); t++; end
    chk("drain_pending", q.size(), 0);
  endtask

  initial begin
    exp_t e;
    int r;
    step(2);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_radicand", radicand, 0);
    chk("rst_nc", non_canonical, 0);
    reset = 0;
    step(1);
    // latency: valid exactly after the fifth edge, for one cycle
    send(15, 30, 255, 0, 1);
    for (int k = 1; k <= 6; k++) begin
      step(1);
      chk($sformatf("latency_valid_edge%0d", k), out_valid, k == 5);
    end
    chk("in_ready_after_handshake", in_ready, 1);
    send(0, 0, 0, 0, 1);
    send(11, 7, 128, 0, 1);
    send(3, 7, 16, 1, 1);
    send(15, 31, 0, 1, 1);
    drain();
    // backpressure: result held, extra requests ignored
    out_ready = 0;
    send(5, 3, 28, 0, 1);
    for (int t = 0; t < 50 && !out_valid; t++) step(1);
    chk("bp_valid_seen", out_valid, 1);
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0]; root = 1; remainder = 1;
      step(1);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_radicand", radicand, 28);
      chk("bp_nc", non_canonical, 0);
    end
    in_valid = 0;
    out_ready = 1;
    step(1);
    chk("release_out_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
    // reset mid-MUL discards the job
    send(7, 2, 0, 0, 0);
    step(1);
    reset = 1;
    step(1);
    reset = 0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_radicand", radicand, 0);
    chk("midrst_nc", non_canonical, 0);
    for (int k = 0; k < 8; k++) begin
      step(1);
      chk("midrst_no_stale", out_valid, 0);
    end
    // full sweep against the model
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 32; b++) begin
        e = model(a, b);
        send(a, b, e.rad, e.nc, 1);
      end
    // round trip from integer square roots
    for (int x = 0; x < 256; x++) begin
      r = 0;
      while ((r + 1) * (r + 1) <= x) r++;
      send(r, x - r * r, x, 0, 1);
    end
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
